// File: rtl/pc_jump_pkg.sv
// Shared types and constants for the program-counter jump controller.
package pc_jump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        LOC  = 2'd3
    } state_t;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;
    localparam logic [2:0] COND_N      = 3'd5;
    localparam logic [2:0] COND_NN     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational evaluation of a jump condition code against the {N,C,Z} flags.
module jump_cond_eval
    import pc_jump_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       pass
);

    // Decode the condition code into a single pass bit.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_ALWAYS: pass = 1'b1;
            COND_Z:      pass = flags[FLAG_Z];
            COND_NZ:     pass = ~flags[FLAG_Z];
            COND_C:      pass = flags[FLAG_C];
            COND_NC:     pass = ~flags[FLAG_C];
            COND_N:      pass = flags[FLAG_N];
            COND_NN:     pass = ~flags[FLAG_N];
            COND_NEVER:  pass = 1'b0;
            default:     pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_jump_ctrl.sv
// Sequences the PC's active-low jump strobes and D bus for a conditional
// 16-bit jump, taking the shortest legal path.
module pc_jump_ctrl
    import pc_jump_pkg::*;
#(
    parameter bit SHORT_OPT   = 1'b1,
    parameter bit HITMP_CACHE = 1'b1,
    parameter bit LOG         = 1'b0
) (
    input  logic        clk,
    input  logic        MR,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [2:0]  req_cond,
    input  logic [2:0]  flags,
    input  logic [7:0]  PCHI,
    input  logic [7:0]  PCLO,
    output logic [7:0]  D,
    output logic        _pchitmp_in,
    output logic        _local_jump,
    output logic        _long_jump,
    output logic        done,
    output logic        taken
);

    state_t      state_r;
    logic [7:0]  lo_r;
    logic [7:0]  hitmp_r;
    logic        hitmp_valid_r;

    logic        pass_s;
    logic        accept_s;
    logic [15:0] pc_next_s;
    logic        local_s;
    logic        nohi_s;
    logic        log_unused_s;

    assign log_unused_s = LOG;

    jump_cond_eval u_cond (
        .cond  (req_cond),
        .flags (flags),
        .pass  (pass_s)
    );

    assign req_ready = (state_r == IDLE) && !MR;
    assign accept_s  = req_valid && req_ready;

    // pc_next is what the PC shows during the strobe cycle; a lo of FF would
    // carry into PC hi on the load edge, so that case must take the long path.
    assign pc_next_s = {PCHI, PCLO} + 16'd1;
    assign local_s   = SHORT_OPT && (pc_next_s[15:8] == req_addr[15:8]) &&
                       (pc_next_s[7:0] != 8'hFF);
    assign nohi_s    = HITMP_CACHE && hitmp_valid_r && (hitmp_r == req_addr[15:8]);

    // Jump sequencer: strobes and D are registered so each strobe spans one full period.
    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            state_r       <= IDLE;
            lo_r          <= 8'h00;
            hitmp_r       <= 8'h00;
            hitmp_valid_r <= 1'b0;
            D             <= 8'h00;
            _pchitmp_in   <= 1'b1;
            _local_jump   <= 1'b1;
            _long_jump    <= 1'b1;
            done          <= 1'b0;
            taken         <= 1'b0;
        end else begin
            done  <= 1'b0;
            taken <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (!pass_s) begin
                            done <= 1'b1;
                        end else if (local_s) begin
                            state_r     <= LOC;
                            D           <= req_addr[7:0];
                            _local_jump <= 1'b0;
                        end else if (nohi_s) begin
                            state_r    <= LO;
                            D          <= req_addr[7:0];
                            _long_jump <= 1'b0;
                        end else begin
                            state_r     <= HI;
                            D           <= req_addr[15:8];
                            lo_r        <= req_addr[7:0];
                            _pchitmp_in <= 1'b0;
                        end
                    end
                end
                HI: begin
                    hitmp_r       <= D;
                    hitmp_valid_r <= 1'b1;
                    _pchitmp_in   <= 1'b1;
                    D             <= lo_r;
                    _long_jump    <= 1'b0;
                    state_r       <= LO;
                end
                LO: begin
                    _long_jump <= 1'b1;
                    done       <= 1'b1;
                    taken      <= 1'b1;
                    state_r    <= IDLE;
                end
                LOC: begin
                    _local_jump <= 1'b1;
                    done        <= 1'b1;
                    taken       <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    _pchitmp_in <= 1'b1;
                    _local_jump <= 1'b1;
                    _long_jump  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Scoreboard bench: a PC consumer model plus a path-level reference model of the jump controller.
module tb_pc_jump_ctrl;

    logic        clk = 1'b0;
    logic        MR = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'h0000;
    logic [2:0]  req_cond = 3'd0;
    logic [2:0]  flags = 3'd0;
    logic [7:0]  D;
    logic        _pchitmp_in, _local_jump, _long_jump, done, taken;

    logic [15:0] pc_model = 16'h0000;
    logic [7:0]  pchitmp_m = 8'h00;
    logic        pc_set_en = 1'b0;
    logic [15:0] pc_set_val = 16'h0000;

    // second instance with the short path disabled
    logic        req_valid2 = 1'b0;
    logic [15:0] req_addr2 = 16'h0000;
    logic        req_ready2;
    logic [7:0]  D2;
    logic        _pchitmp_in2, _local_jump2, _long_jump2, done2, taken2;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic            tk;
        logic [15:0]     addr;
        logic [1:0]      n;
        logic [1:0][1:0] kind;
        logic [1:0][7:0] dv;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] obs_kind[$];
    logic [7:0] obs_d[$];

    logic [7:0] ref_hitmp = 8'h00;
    logic       ref_valid = 1'b0;

    always #5 clk = ~clk;

    pc_jump_ctrl dut (
        .clk(clk), .MR(MR), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_cond(req_cond), .flags(flags),
        .PCHI(pc_model[15:8]), .PCLO(pc_model[7:0]), .D(D),
        ._pchitmp_in(_pchitmp_in), ._local_jump(_local_jump), ._long_jump(_long_jump),
        .done(done), .taken(taken)
    );

    pc_jump_ctrl #(.SHORT_OPT(1'b0)) dut2 (
        .clk(clk), .MR(MR), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr2), .req_cond(3'd0), .flags(3'd0),
        .PCHI(8'h12), .PCLO(8'h34), .D(D2),
        ._pchitmp_in(_pchitmp_in2), ._local_jump(_local_jump2), ._long_jump(_long_jump2),
        .done(done2), .taken(taken2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // PC consumer: increments every cycle unless a jump strobe loads it.
    always @(posedge clk) begin
        if (!_pchitmp_in) pchitmp_m <= D;
        if (pc_set_en)
            pc_model <= pc_set_val;
        else if (!_long_jump)
            pc_model <= {pchitmp_m, D};
        else if (!_local_jump)
            pc_model <= {pc_model[15:8] + ((pc_model[7:0] == 8'hFF) ? 8'd1 : 8'd0), D};
        else
            pc_model <= pc_model + 16'd1;
    end

    function automatic bit ref_pass(input logic [2:0] c, input logic [2:0] f);
        bit z, cy, ng;
        z = f[0]; cy = f[1]; ng = f[2];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return ng;
            3'd6: return !ng;
            default: return 1'b0;
        endcase
    endfunction

    // Wait for ready, optionally set the PC, then present one request and push its expectation.
    task automatic issue(input logic [15:0] a, input logic [2:0] c, input logic [2:0] f,
                         input bit setpc, input logic [15:0] pcv);
        int guard;
        exp_t e;
        logic [15:0] pcn;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'd1, 32'd0);
        if (setpc) begin
            pc_set_val = pcv;
            pc_set_en = 1'b1;
            @(negedge clk);
            pc_set_en = 1'b0;
        end
        pcn = pc_model + 16'd1;
        e = '0;
        e.addr = a;
        if (ref_pass(c, f)) begin
            e.tk = 1'b1;
            if (pcn[15:8] == a[15:8] && pcn[7:0] != 8'hFF) begin
                e.n = 2'd1; e.kind[0] = 2'd2; e.dv[0] = a[7:0];
            end else if (ref_valid && ref_hitmp == a[15:8]) begin
                e.n = 2'd1; e.kind[0] = 2'd3; e.dv[0] = a[7:0];
            end else begin
                e.n = 2'd2; e.kind[0] = 2'd1; e.dv[0] = a[15:8];
                e.kind[1] = 2'd3; e.dv[1] = a[7:0];
                ref_hitmp = a[15:8];
                ref_valid = 1'b1;
            end
        end
        exp_q.push_back(e);
        req_addr = a; req_cond = c; flags = f; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 16'($urandom);
        req_cond = 3'($urandom);
        flags = 3'($urandom);
    endtask

    // Monitor: record strobe cycles and score each retirement against the queue.
    always @(negedge clk) begin
        if (!MR) begin
            chk("one_strobe", 32'((!_pchitmp_in) + (!_local_jump) + (!_long_jump) <= 1), 32'd1);
            chk("one_strobe2", 32'((!_pchitmp_in2) + (!_local_jump2) + (!_long_jump2) <= 1), 32'd1);
            if (!_pchitmp_in) begin obs_kind.push_back(2'd1); obs_d.push_back(D); end
            if (!_local_jump) begin obs_kind.push_back(2'd2); obs_d.push_back(D); end
            if (!_long_jump)  begin obs_kind.push_back(2'd3); obs_d.push_back(D); end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("taken", 32'(taken), 32'(e.tk));
                    chk("nstrobes", 32'(obs_kind.size()), 32'(e.n));
                    for (int i = 0; i < obs_kind.size() && i < int'(e.n); i++) begin
                        chk("strobe_kind", 32'(obs_kind[i]), 32'(e.kind[i]));
                        chk("strobe_d", 32'(obs_d[i]), 32'(e.dv[i]));
                    end
                    if (e.tk) chk("pc_after", 32'(pc_model), 32'(e.addr));
                end
                obs_kind.delete();
                obs_d.delete();
            end
        end
    end

    initial begin
        int guard;
        #1 MR = 1'b1;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_strobes", {29'd0, _pchitmp_in, _local_jump, _long_jump}, 32'd7);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_done", {30'd0, done, taken}, 32'd0);
        @(negedge clk); @(negedge clk);
        #2 MR = 1'b0;

        issue(16'h1250, 3'd0, 3'd0, 1'b1, 16'h1234);   // local
        issue(16'h1210, 3'd0, 3'd0, 1'b1, 16'h12FE);   // FF exclusion -> long
        issue(16'h3400, 3'd0, 3'd0, 1'b1, 16'h1000);   // long, caches 0x34
        issue(16'h3480, 3'd0, 3'd0, 1'b1, 16'h20F0);   // cached hi -> lo only
        issue(16'h4000, 3'd1, 3'd0, 1'b0, 16'h0000);   // Z false
        issue(16'h4000, 3'd7, 3'd7, 1'b0, 16'h0000);   // never
        issue(16'h4000, 3'd1, 3'd1, 1'b1, 16'h0100);   // Z true -> long

        // reset in the HI cycle of a long jump
        issue(16'h5600, 3'd0, 3'd0, 1'b1, 16'h0100);
        chk("hi_cycle", {30'd0, _pchitmp_in, D == 8'h56}, 32'd1);
        #2 MR = 1'b1;
        #1;
        chk("mid_rst_strobes", {29'd0, _pchitmp_in, _local_jump, _long_jump}, 32'd7);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        obs_kind.delete();
        obs_d.delete();
        ref_valid = 1'b0;
        @(negedge clk);
        #2 MR = 1'b0;
        issue(16'h5610, 3'd0, 3'd0, 1'b1, 16'h0100);   // cache cleared -> full long

        for (int k = 0; k < 150; k++) begin
            logic [7:0] his[3];
            logic [15:0] a, p;
            his[0] = 8'h12; his[1] = 8'h13; his[2] = 8'h34;
            a = {his[$urandom_range(0, 2)], 8'($urandom)};
            p = {his[$urandom_range(0, 2)], ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom)};
            issue(a, 3'($urandom_range(0, 7)), 3'($urandom), ($urandom_range(0, 1) == 1), p);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        // same-page target with the short path disabled
        @(negedge clk);
        chk("d2_ready", 32'(req_ready2), 32'd1);
        req_addr2 = 16'h1250;
        req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        req_addr2 = 16'h0000;
        chk("d2_hi", {21'd0, _pchitmp_in2, _local_jump2, _long_jump2, D2}, {21'd0, 3'b011, 8'h12});
        @(negedge clk);
        chk("d2_lo", {21'd0, _pchitmp_in2, _local_jump2, _long_jump2, D2}, {21'd0, 3'b110, 8'h50});
        @(negedge clk);
        chk("d2_done", {30'd0, done2, taken2}, 32'd3);
        chk("d2_idle", {29'd0, _pchitmp_in2, _local_jump2, _long_jump2}, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
